// File: rtl/riscv_osd_him_peer_if.sv
// ----------------------------------------------------------------------------
// riscv_osd_him_peer_if : DII / GLIP stream bundle for the host-side HIM peer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface riscv_osd_him_peer_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] dii_in_data;
  logic            dii_in_last;
  logic            dii_in_valid;
  logic            dii_in_ready;

  logic [XLEN-1:0] glip_out_data;
  logic            glip_out_valid;
  logic            glip_out_ready;

  logic [XLEN-1:0] glip_in_data;
  logic            glip_in_valid;
  logic            glip_in_ready;

  logic [XLEN-1:0] dii_out_data;
  logic            dii_out_last;
  logic            dii_out_valid;
  logic            dii_out_ready;

  logic            err_overflow;

  // master: host environment driving the peer
  modport master (
    output dii_in_data, dii_in_last, dii_in_valid,
    input  dii_in_ready,
    input  glip_out_data, glip_out_valid,
    output glip_out_ready,
    output glip_in_data, glip_in_valid,
    input  glip_in_ready,
    input  dii_out_data, dii_out_last, dii_out_valid,
    output dii_out_ready,
    input  err_overflow
  );

  // slave: the peer itself
  modport slave (
    input  dii_in_data, dii_in_last, dii_in_valid,
    output dii_in_ready,
    output glip_out_data, glip_out_valid,
    input  glip_out_ready,
    input  glip_in_data, glip_in_valid,
    output glip_in_ready,
    output dii_out_data, dii_out_last, dii_out_valid,
    input  dii_out_ready,
    output err_overflow
  );
endinterface

`default_nettype wire

// File: rtl/riscv_osd_him_peer.sv
// ----------------------------------------------------------------------------
// riscv_osd_him_peer : host-side DII <-> length-prefixed GLIP word bridge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module riscv_osd_him_peer #(
  parameter int XLEN        = 64,
  parameter int BUFFER_SIZE = 4
) (
  input  logic                clk,
  input  logic                rstn,
  riscv_osd_him_peer_if.slave bus
);

  localparam int CW = $clog2(BUFFER_SIZE) + 1;
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam logic [CW-1:0] C_FULL = CW'(BUFFER_SIZE);

  typedef enum logic [1:0] {
    TX_FILL = 2'd0,
    TX_HDR  = 2'd1,
    TX_DATA = 2'd2
  } tx_state_e;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_DATA = 1'b1
  } rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] mem_q [BUFFER_SIZE];
  logic            wr_en;
  logic [AW-1:0]   wr_addr;

  rx_state_e       rx_state_q, rx_state_d;
  logic [4:0]      remaining_q, remaining_d;

  assign wr_addr          = count_q[AW-1:0];
  assign bus.err_overflow = err_q;

  // TX: collect a whole packet, then emit size word followed by the flits
  always_comb begin
    tx_state_d         = tx_state_q;
    count_d            = count_q;
    rd_d               = rd_q;
    err_d              = err_q;
    wr_en              = 1'b0;
    bus.dii_in_ready   = 1'b0;
    bus.glip_out_valid = 1'b0;
    bus.glip_out_data  = '0;
    unique case (tx_state_q)
      TX_FILL: begin
        bus.dii_in_ready = 1'b1;
        if (bus.dii_in_valid) begin
          if (count_q < C_FULL) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
          if (bus.dii_in_last) begin
            tx_state_d = TX_HDR;
          end
        end
      end
      TX_HDR: begin
        bus.glip_out_valid = 1'b1;
        bus.glip_out_data  = XLEN'(count_q);
        if (bus.glip_out_ready) begin
          tx_state_d = TX_DATA;
          rd_d       = '0;
        end
      end
      TX_DATA: begin
        bus.glip_out_valid = 1'b1;
        bus.glip_out_data  = mem_q[rd_q];
        if (bus.glip_out_ready) begin
          rd_d = rd_q + AW'(1);
          if ({1'b0, rd_q} == (count_q - CW'(1))) begin
            count_d    = '0;
            tx_state_d = TX_FILL;
          end
        end
      end
      default: tx_state_d = TX_FILL;
    endcase
  end

  // Packet storage carries no reset; count_q alone marks valid entries
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= bus.dii_in_data;
    end
  end

  // RX: size word in IDLE, then a zero-latency pass-through for n words
  always_comb begin
    rx_state_d        = rx_state_q;
    remaining_d       = remaining_q;
    bus.glip_in_ready = 1'b1;
    bus.dii_out_valid = 1'b0;
    bus.dii_out_last  = 1'b0;
    bus.dii_out_data  = bus.glip_in_data;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (bus.glip_in_valid && (bus.glip_in_data[4:0] != 5'd0)) begin
          remaining_d = bus.glip_in_data[4:0];
          rx_state_d  = RX_DATA;
        end
      end
      RX_DATA: begin
        bus.glip_in_ready = bus.dii_out_ready;
        bus.dii_out_valid = bus.glip_in_valid;
        bus.dii_out_last  = (remaining_q == 5'd1);
        if (bus.glip_in_valid && bus.dii_out_ready) begin
          remaining_d = remaining_q - 5'd1;
          if (remaining_q == 5'd1) begin
            rx_state_d = RX_IDLE;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q  <= TX_FILL;
      count_q     <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      rx_state_q  <= RX_IDLE;
      remaining_q <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      rx_state_q  <= rx_state_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

`default_nettype wire
